// File: rtl/pipemem_arbiter_if.sv
// Requester-side bus of the pipelined memory arbiter: request/command fields
// from the requester, grant and read-response pulses back from the arbiter.
interface pipemem_arbiter_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req,
      output we,
      output addr,
      output wdata,
      input  gnt,
      input  rvalid,
      input  rdata
   );

   modport slave (
      input  req,
      input  we,
      input  addr,
      input  wdata,
      output gnt,
      output rvalid,
      output rdata
   );
endinterface

// File: rtl/pipemem_arbiter.sv
// Two-port arbiter in front of a single-port pipelined data memory: one
// transaction at a time, fixed priority to port A with a starvation guard for B.
module pipemem_arbiter #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned RD_LAT     = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              clrn,
   pipemem_arbiter_if.slave  a,
   pipemem_arbiter_if.slave  b,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              busy
);

   localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
   localparam int unsigned LatW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e            state;
   logic [CntW-1:0]   starve_cnt;
   logic [LatW-1:0]   lat_cnt;
   logic              owner_b;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_din_q;
   logic              a_rvalid_q;
   logic              b_rvalid_q;
   logic [DATA_W-1:0] a_rdata_q;
   logic [DATA_W-1:0] b_rdata_q;

   logic starved;
   logic win_a;
   logic win_b;
   logic idle;

   always_comb begin
      idle    = (state == StIdle);
      starved = b.req && (starve_cnt == CntW'(STARVE_MAX));
      win_a   = a.req && !starved;
      win_b   = b.req && !win_a;
   end

   // Grants are gated by clrn so a request seen during reset is never lost.
   assign a.gnt    = clrn && idle && win_a;
   assign b.gnt    = clrn && idle && win_b;
   assign a.rvalid = a_rvalid_q;
   assign b.rvalid = b_rvalid_q;
   assign a.rdata  = a_rdata_q;
   assign b.rdata  = b_rdata_q;
   assign mem_we   = mem_we_q;
   assign mem_addr = mem_addr_q;
   assign mem_din  = mem_din_q;
   assign busy     = !idle;

   always_ff @(posedge clk) begin
      if (!clrn) begin
         state      <= StIdle;
         starve_cnt <= '0;
         lat_cnt    <= '0;
         owner_b    <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
      end else begin
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         unique case (state)
            StIdle: begin
               if (win_a || win_b) begin
                  owner_b    <= win_b;
                  mem_we_q   <= win_a ? a.we : b.we;
                  mem_addr_q <= win_a ? a.addr : b.addr;
                  mem_din_q  <= win_a ? a.wdata : b.wdata;
                  state      <= StIssue;
               end
               // win_a with b.req implies starve_cnt < STARVE_MAX, so this saturates.
               if (win_b || !b.req) begin
                  starve_cnt <= '0;
               end else if (win_a && (starve_cnt != CntW'(STARVE_MAX))) begin
                  starve_cnt <= starve_cnt + CntW'(1);
               end
            end
            StIssue: begin
               mem_we_q <= 1'b0;
               if (mem_we_q) begin
                  state <= StIdle;
               end else if (RD_LAT == 1) begin
                  state <= StResp;
               end else begin
                  lat_cnt <= LatW'(RD_LAT - 1);
                  state   <= StWait;
               end
            end
            StWait: begin
               lat_cnt <= lat_cnt - LatW'(1);
               if (lat_cnt == LatW'(1)) begin
                  state <= StResp;
               end
            end
            StResp: begin
               if (owner_b) begin
                  b_rdata_q  <= mem_dout;
                  b_rvalid_q <= 1'b1;
               end else begin
                  a_rdata_q  <= mem_dout;
                  a_rvalid_q <= 1'b1;
               end
               state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/pipemem_arbiter.md
Name: pipemem_arbiter

Overview:
- Shares the single-port pipelined data memory (registered address/data-in, registered data-out, 2-cycle read latency) between two requesters.
- Port A is the CPU MEM stage; port B is a debug/DMA loader.
- Issues one transaction at a time, tracks the read latency, and returns read data to the originating port with a one-cycle valid pulse.
- Fixed priority to A, with a starvation guard for B.

Parameters:
- DATA_W, 32, data width of requester and memory data buses
- ADDR_W, 32, byte-address width, passed through unchanged
- RD_LAT, 2, cycles from mem_addr driven to mem_dout valid (min 1)
- STARVE_MAX, 4, consecutive A-grants, while B is requesting, after which B wins the next arbitration (min 1)

Ports:
- clk  in  1  system clock, rising edge
- clrn  in  1  synchronous active-low reset
- a_req  in  1  port A request; held with a_we/a_addr/a_wdata until a_gnt
- a_we  in  1  port A: 1 = write, 0 = read
- a_addr  in  ADDR_W  port A byte address
- a_wdata  in  DATA_W  port A write data
- a_gnt  out  1  one-cycle pulse: A's request accepted this cycle
- a_rvalid  out  1  one-cycle pulse: a_rdata holds A's read result
- a_rdata  out  DATA_W  read data for port A
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: identical to port A, for port B
- mem_we  out  1  memory write enable, registered level
- mem_addr  out  ADDR_W  memory address, registered
- mem_din  out  DATA_W  memory write data, registered
- mem_dout  in  DATA_W  memory read data
- busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset: clrn sampled low at a rising edge forces the following.
  - FSM to IDLE.
  - All outputs to 0, including rdata registers and mem_* outputs.
  - Starvation counter and owner flag cleared.
  - An in-flight read is dropped: no rvalid is produced for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE (busy=0):
  - If any req is high, pick a winner and pulse that port's gnt combinationally in this cycle (cycle T).
  - Latch the winner's we/addr/wdata and the owner flag; go to ISSUE.
  - No req: stay in IDLE.
- Arbitration:
  - A wins if a_req && !(b_req && starve_cnt == STARVE_MAX); otherwise B wins if b_req.
- Starvation counter (saturating at STARVE_MAX):
  - Increments when A is granted while b_req=1.
  - Clears when B is granted.
  - Clears when b_req=0 in IDLE.
- ISSUE (cycle T+1): mem_addr/mem_din hold the latched values; mem_we = latched we for exactly this cycle.
  - Write: next state IDLE. Next grant possible at T+2, i.e. one write per 2 cycles.
  - Read: load latency counter with RD_LAT-1; go to WAIT. mem_we stays 0.
- WAIT:
  - Decrement the counter; mem_addr stays stable.
  - When the counter reaches 0 (cycle T+RD_LAT), go to RESP.
  - For RD_LAT=1, WAIT is skipped and ISSUE goes directly to RESP.
- RESP (cycle T+1+RD_LAT): capture mem_dout into the owner's rdata register; go to IDLE.
  - Owner's rvalid is high in cycle T+2+RD_LAT for one cycle, with rdata valid.
  - rdata holds its value until the next read for that port completes.
  - The next grant is possible in the same cycle as rvalid.
- Requests while busy=1 are not granted and not lost: the requester holds req until gnt.
- gnt is never asserted to both ports in one cycle.
- Addresses pass through unmodified, including addr[1:0].
- Non-owner rvalid is always 0.
- Simultaneous a_req and b_req with starve_cnt < STARVE_MAX: A wins, B waits.
- Reset asserted during WAIT or RESP: no rvalid, mem_we=0 at the next cycle, FSM in IDLE.

Test Plan:
- A write of 0xDEADBEEF to 0x10 at T, then A read of 0x10 -> a_gnt at T; mem_we=1 with mem_addr=0x10 only at T+1; read gnt at T+2; a_rvalid at T+6 with a_rdata=0xDEADBEEF; b_rvalid=0 throughout.
- a_req and b_req both held high with reads, STARVE_MAX=4 -> grant order A,A,A,A,B,A,...; never two gnts in one cycle.
- B write of 0x12345678 to 0x7C while A is mid-read -> b_gnt delayed until the cycle of a_rvalid; mem_we pulses once with mem_din=0x12345678.
- clrn low during WAIT of an A read -> no a_rvalid; busy=0, mem_we=0, and all gnt/rvalid outputs 0 after the reset edge; a new A read afterwards returns correct data.
- Back-to-back A writes to 0x00, 0x04, 0x08 -> a_gnt every 2 cycles; mem_we high for exactly 3 single cycles with matching addresses.
- RD_LAT=1 build, A read -> a_rvalid at T+3.
